// File: rtl/edge_interrupt_controller_if.sv
// Interrupt offer handshake between the edge interrupt controller and the CPU.
// The controller drives the master side; the CPU interrupt logic is the slave.
interface edge_interrupt_controller_if #(
    parameter int unsigned INDEX_WIDTH = 3
);
    logic                   irqValid;
    logic [INDEX_WIDTH-1:0] irqIndex;
    logic                   irqAck;

    modport master (
        output irqValid,
        output irqIndex,
        input  irqAck
    );

    modport slave (
        input  irqValid,
        input  irqIndex,
        output irqAck
    );
endinterface

// File: rtl/edge_interrupt_controller.sv
// Per-line edge detectors with configurable trigger mode and sticky pending bits,
// followed by a fixed-priority (lowest index wins) arbiter offering one line at a time.
module edge_interrupt_controller #(
    parameter int unsigned LINES       = 8,
    parameter int unsigned INDEX_WIDTH = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [LINES-1:0]         lineIn,
    input  logic                     configWrite,
    input  logic [2*LINES-1:0]       configMode,
    output logic [LINES-1:0]         pendingOut,
    edge_interrupt_controller_if.master irq
);

    typedef enum logic [0:0] {StIdle, StOffer} state_e;

    state_e                 state_q, state_d;
    logic [LINES-1:0]       prev_q, prev_d;
    logic [2*LINES-1:0]     mode_q, mode_d;
    logic [LINES-1:0]       pending_q, pending_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [LINES-1:0]       qualify;
    logic [INDEX_WIDTH-1:0] lowest;

    // Edges are judged against the mode currently held, not the one being written.
    always_comb begin
        qualify = '0;
        for (int i = 0; i < LINES; i++) begin
            qualify[i] = (lineIn[i] & ~prev_q[i] & mode_q[2*i])
                       | (~lineIn[i] & prev_q[i] & mode_q[2*i+1]);
        end
    end

    always_comb begin
        lowest = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (pending_q[i]) lowest = INDEX_WIDTH'(i);
        end
    end

    always_comb begin
        prev_d    = lineIn;
        mode_d    = configWrite ? configMode : mode_q;
        pending_d = pending_q;
        if (configWrite) begin
            for (int i = 0; i < LINES; i++) begin
                if (configMode[2*i +: 2] == 2'b00) pending_d[i] = 1'b0;
            end
        end
        if ((state_q == StOffer) && irq.irqAck) pending_d[index_q] = 1'b0;
        // A fresh qualifying edge outranks any clear in the same cycle.
        pending_d = pending_d | qualify;
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        case (state_q)
            StIdle: begin
                if (|pending_q) begin
                    index_d = lowest;
                    state_d = StOffer;
                end
            end
            StOffer: begin
                if (irq.irqAck) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            prev_q    <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            index_q   <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            index_q   <= index_d;
        end
    end

    assign irq.irqValid = (state_q == StOffer);
    assign irq.irqIndex = index_q;
    assign pendingOut   = pending_q;

endmodule

// File: tb/tb_edge_interrupt_controller.sv
// Directed bench for edge_interrupt_controller: expected offers are queued by the
// stimulus and checked by an independent monitor as each new offer appears.
module tb_edge_interrupt_controller;

    localparam int unsigned LINES       = 8;
    localparam int unsigned INDEX_WIDTH = 3;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [LINES-1:0]       lineIn;
    logic                   configWrite;
    logic [2*LINES-1:0]     configMode;
    logic [LINES-1:0]       pendingOut;

    edge_interrupt_controller_if #(.INDEX_WIDTH(INDEX_WIDTH)) irq_bus ();

    edge_interrupt_controller #(
        .LINES       (LINES),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .lineIn      (lineIn),
        .configWrite (configWrite),
        .configMode  (configMode),
        .pendingOut  (pendingOut),
        .irq         (irq_bus.master)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    logic [INDEX_WIDTH-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rising irqValid is a new offer and must match the queue head.
    initial begin
        logic seen;
        seen = 1'b0;
        forever begin
            @(negedge clock);
            if (irq_bus.irqValid && !seen) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL offer: unexpected offer of line %0d, expected none",
                             irq_bus.irqIndex);
                end else begin
                    check("offer_index", 32'(irq_bus.irqIndex), 32'(exp_q.pop_front()));
                end
            end
            seen = irq_bus.irqValid;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_mode(input logic [2*LINES-1:0] m);
        configMode  = m;
        configWrite = 1'b1;
        tick();
        configWrite = 1'b0;
    endtask

    task automatic ack_offer();
        irq_bus.irqAck = 1'b1;
        tick();
        irq_bus.irqAck = 1'b0;
    endtask

    task automatic check_state(input string name, input logic [LINES-1:0] pend,
                               input logic valid);
        check({name, "_pending"}, 32'(pendingOut), 32'(pend));
        check({name, "_valid"}, 32'(irq_bus.irqValid), 32'(valid));
    endtask

    initial begin
        reset          = 1'b0;
        lineIn         = 8'hFF;
        configWrite    = 1'b0;
        configMode     = '0;
        irq_bus.irqAck = 1'b0;
        #23;
        check_state("reset", 8'h00, 1'b0);
        check("reset_index", 32'(irq_bus.irqIndex), 32'd0);
        #4 reset = 1'b1;

        // All lines disabled: toggling must never raise anything.
        for (int i = 0; i < 20; i++) begin
            lineIn = ~lineIn;
            tick();
            check_state("disabled", 8'h00, 1'b0);
        end
        lineIn = 8'h00;
        tick();
        tick();

        // Rising mode on line 2.
        write_mode(16'h0010);
        lineIn[2] = 1'b1;
        exp_q.push_back(3'd2);
        tick();
        check_state("rise_k", 8'h04, 1'b0);
        tick();
        check_state("rise_k1", 8'h04, 1'b1);
        ack_offer();
        check_state("rise_ack", 8'h00, 1'b0);
        lineIn[2] = 1'b0;
        tick();
        tick();
        check_state("rise_fall_ignored", 8'h00, 1'b0);

        // Falling mode on line 0.
        write_mode(16'h0012);
        lineIn[0] = 1'b1;
        tick();
        tick();
        check_state("fall_rise_ignored", 8'h00, 1'b0);
        lineIn[0] = 1'b0;
        exp_q.push_back(3'd0);
        tick();
        check_state("fall_k", 8'h01, 1'b0);
        tick();
        check_state("fall_k1", 8'h01, 1'b1);
        ack_offer();
        check_state("fall_ack", 8'h00, 1'b0);

        // Priority: lines 1 and 5 in any-edge mode, toggled together.
        write_mode(16'h0C0C);
        lineIn = 8'h22;
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd5);
        tick();
        check_state("prio_k", 8'h22, 1'b0);
        tick();
        check("prio_first_index", 32'(irq_bus.irqIndex), 32'd1);
        ack_offer();
        check_state("prio_ack1", 8'h20, 1'b0);
        tick();
        check_state("prio_second", 8'h20, 1'b1);
        check("prio_second_index", 32'(irq_bus.irqIndex), 32'd5);
        ack_offer();
        check_state("prio_ack2", 8'h00, 1'b0);

        // Ack collides with a new edge on line 3.
        write_mode(16'h00C0);
        lineIn[3] = 1'b1;
        exp_q.push_back(3'd3);
        tick();
        tick();
        check_state("coll_offer", 8'h08, 1'b1);
        irq_bus.irqAck = 1'b1;
        lineIn[3]      = 1'b0;
        exp_q.push_back(3'd3);
        tick();
        irq_bus.irqAck = 1'b0;
        check_state("coll_ack", 8'h08, 1'b0);
        tick();
        check_state("coll_reoffer", 8'h08, 1'b1);
        ack_offer();
        check_state("coll_done", 8'h00, 1'b0);

        // Asynchronous reset while an offer is outstanding.
        lineIn[3] = 1'b1;
        exp_q.push_back(3'd3);
        tick();
        tick();
        check_state("rst_offer", 8'h08, 1'b1);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check_state("rst_async", 8'h00, 1'b0);
        check("rst_async_index", 32'(irq_bus.irqIndex), 32'd0);
        tick();
        #3 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lineIn[3] = ~lineIn[3];
            tick();
        end
        check_state("rst_modes_cleared", 8'h00, 1'b0);

        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/edge_interrupt_controller.md
# edge_interrupt_controller

Interrupt front-end for the ECO32 core that turns up to LINES external request lines into edge-triggered interrupt events. Each line gets a per-line synchronous edge detector with a software-configurable trigger mode (disabled / rising / falling / any edge) and a sticky pending bit. A fixed-priority arbiter then presents one pending line at a time to the CPU interrupt logic over a valid/acknowledge handshake.

## Interface
- LINES, 8: number of interrupt request lines (1..32).
- INDEX_WIDTH, 3: width of irqIndex; must satisfy 2^INDEX_WIDTH >= LINES.

- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- lineIn  in  LINES  request levels; already synchronized to clock by the caller.
- configWrite  in  1  when 1 at a clock edge, load configMode into the mode registers.
- configMode  in  2*LINES  per-line mode, bits [2i+1:2i] for line i: 00 disabled, 01 rising, 10 falling, 11 any edge.
- irqValid  out  1  an interrupt is being offered.
- irqIndex  out  INDEX_WIDTH  number of the offered line; valid only while irqValid=1.
- irqAck  in  1  CPU accepts the offered interrupt.
- pendingOut  out  LINES  current pending bits.

## Operation
- Reset values: previous-sample register 0, mode registers 00 (all lines disabled), pending 0, irqValid 0, irqIndex 0, FSM IDLE.
- Edge detection per line i: rise = lineIn[i] & ~prev[i]; fall = ~lineIn[i] & prev[i]. prev[i] <= lineIn[i] every cycle, regardless of mode.
- Qualifying edge: rise with mode 01 or 11, or fall with mode 10 or 11. Mode 00 never qualifies.
- Edges are evaluated with the mode held before the edge. A configWrite in the same cycle affects only later cycles.
- Pending bit i:
  - set on a qualifying edge;
  - cleared by an ack of line i;
  - cleared by a configWrite that gives line i mode 00.
  - Priority: set > ack-clear. A new qualifying edge in the ack cycle leaves the bit set.
- Arbiter FSM, two states:
  - IDLE: irqValid=0. If any pending bit is 1, latch irqIndex with the lowest-numbered pending line and go to OFFER. irqAck is ignored.
  - OFFER: irqValid=1 and irqIndex is held stable. On irqAck=1, clear pending[irqIndex] (subject to the set priority) and go to IDLE.
- irqValid never drops without an ack. If the offered line is disabled while in OFFER, its pending bit clears but the offer stays until acked; that ack has no further effect.
- Pending bits set after irqIndex is latched do not change the current offer. A higher-priority line is seen only at the next IDLE.
- Reset mid-operation: all state returns to reset values immediately, with no clock edge needed. Any in-flight offer is lost.

## Timing
- Latency, lineIn change to offer: the change is set up before clock edge k. pendingOut updates after edge k. irqValid=1 with the correct irqIndex after edge k+1.
- Ack: sampled at edge m. irqValid=0 and the pending bit cleared after edge m.
- Next offer: earliest after edge m+1. There is exactly one IDLE cycle between consecutive grants.
- configWrite: sampled at edge k; the new modes apply to edges evaluated at edge k+1 onward.
- All outputs come directly from registers; there are no combinational paths from inputs to outputs.

## Test plan
- Reset and disabled lines: hold reset=0, drive lineIn=0xFF, then release reset with all modes 00 and toggle lineIn → pendingOut=0x00, irqValid=0 for 20 cycles.
- Rising mode, line 2: write mode 01 for line 2, then lineIn[2] 0→1 → pendingOut=0x04 one edge later; irqValid=1, irqIndex=2 the next edge. Pulse irqAck → irqValid=0, pendingOut=0x00. Then lineIn[2] 1→0 → no pending.
- Falling mode, line 0: lineIn[0] 0→1 → nothing. Then 1→0 → pendingOut=0x01, irqIndex=0.
- Priority, lines 1 and 5 in mode 11: toggle both in the same cycle → pendingOut=0x22. First offer is irqIndex=1. Ack it → one cycle with irqValid=0, then irqIndex=5. Ack → pendingOut=0x00.
- Ack collides with a new edge on line 3 (mode 11): ack in the same cycle the line toggles → pendingOut stays 0x08; line 3 is re-offered after one IDLE cycle.
- Reset during OFFER: assert reset mid-cycle while irqValid=1 → irqValid, pendingOut and irqIndex go to 0 before the next clock edge. After release, line edges are ignored until modes are rewritten.
